// File: rtl/des_pkg.sv
// Shared types and constants for the DES core scheduler.
// Holds the FSM state encoding, mode constants and block/key widths.
package des_pkg;

   localparam int unsigned DES_BLOCK_W = 64;
   localparam int unsigned DES_KEY_W   = 64;

   localparam logic MODE_ENCRYPT = 1'b0;
   localparam logic MODE_DECRYPT = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StRun,
      StResp
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// channel that was not served last (last_i = 1 means channel 1 was served last).
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = req_i;
      if (req_i == 2'b11) begin
         sel_o = last_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/des_core_scheduler.sv
// Two-channel job scheduler in front of a single DES core: arbitrates requests,
// runs one job at a time with a timeout, and hands the result back per channel.
module des_core_scheduler
   import des_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0,
   input  logic                   req1,
   input  logic [DES_BLOCK_W-1:0] msg0,
   input  logic [DES_BLOCK_W-1:0] msg1,
   input  logic [DES_KEY_W-1:0]   key0,
   input  logic [DES_KEY_W-1:0]   key1,
   input  logic                   mode0,
   input  logic                   mode1,
   output logic                   grant0,
   output logic                   grant1,
   output logic                   rsp_valid0,
   output logic                   rsp_valid1,
   output logic [DES_BLOCK_W-1:0] rsp_data,
   output logic                   rsp_err,
   input  logic                   rsp_ack0,
   input  logic                   rsp_ack1,
   output logic [DES_BLOCK_W-1:0] core_message,
   output logic [DES_KEY_W-1:0]   core_key,
   output logic                   core_mode,
   output logic                   core_enable,
   input  logic                   core_done,
   input  logic [DES_BLOCK_W-1:0] core_result,
   output logic                   core_ack,
   output logic                   core_abort,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] TimerLast = CNT_W'(TIMEOUT_CYCLES - 1);

   sched_state_e            state_q;
   logic                    chan_q;
   logic                    last_q;
   logic [CNT_W-1:0]        timer_q;
   logic [1:0]              grant_q;
   logic [1:0]              rsp_valid_q;
   logic [DES_BLOCK_W-1:0]  rsp_data_q;
   logic                    rsp_err_q;
   logic [DES_BLOCK_W-1:0]  msg_q;
   logic [DES_KEY_W-1:0]    key_q;
   logic                    mode_q;
   logic                    enable_q;
   logic                    ack_q;
   logic                    abort_q;
   logic                    busy_q;
   logic [1:0]              sel;
   logic                    ack_granted;

   rr_arbiter2 u_arb (
      .req_i  ({req1, req0}),
      .last_i (last_q),
      .sel_o  (sel)
   );

   assign ack_granted = chan_q ? rsp_ack1 : rsp_ack0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         chan_q      <= 1'b0;
         last_q      <= 1'b1;
         timer_q     <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         msg_q       <= '0;
         key_q       <= '0;
         mode_q      <= MODE_ENCRYPT;
         enable_q    <= 1'b0;
         ack_q       <= 1'b0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         grant_q <= '0;
         ack_q   <= 1'b0;
         abort_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (sel != 2'b00) begin
                  chan_q   <= sel[1];
                  msg_q    <= sel[1] ? msg1 : msg0;
                  key_q    <= sel[1] ? key1 : key0;
                  mode_q   <= sel[1] ? mode1 : mode0;
                  grant_q  <= sel;
                  enable_q <= 1'b1;
                  busy_q   <= 1'b1;
                  timer_q  <= '0;
                  state_q  <= StStart;
               end
            end
            StStart: begin
               timer_q <= timer_q + CNT_W'(1);
               state_q <= StRun;
            end
            StRun: begin
               // A done in the timeout cycle takes precedence over the abort.
               if (core_done) begin
                  rsp_data_q  <= core_result;
                  rsp_err_q   <= 1'b0;
                  ack_q       <= 1'b1;
                  enable_q    <= 1'b0;
                  rsp_valid_q <= chan_q ? 2'b10 : 2'b01;
                  state_q     <= StResp;
               end else if (timer_q >= TimerLast) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  abort_q     <= 1'b1;
                  enable_q    <= 1'b0;
                  rsp_valid_q <= chan_q ? 2'b10 : 2'b01;
                  state_q     <= StResp;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
            StResp: begin
               if (ack_granted) begin
                  rsp_valid_q <= '0;
                  last_q      <= chan_q;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant0       = grant_q[0];
   assign grant1       = grant_q[1];
   assign rsp_valid0   = rsp_valid_q[0];
   assign rsp_valid1   = rsp_valid_q[1];
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign core_message = msg_q;
   assign core_key     = key_q;
   assign core_mode    = mode_q;
   assign core_enable  = enable_q;
   assign core_ack     = ack_q;
   assign core_abort   = abort_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_des_core_scheduler.sv
// Self-checking bench: dut_a runs with the default timeout, dut_b with an 8-cycle
// timeout; expected behaviour comes from a channel-level model of the job protocol.
module tb_des_core_scheduler;

   localparam int TO_A = 1023;
   localparam int TO_B = 8;

   logic        clk;
   logic        rst          [2];
   logic        req0         [2];
   logic        req1         [2];
   logic [63:0] msg0         [2];
   logic [63:0] msg1         [2];
   logic [63:0] key0         [2];
   logic [63:0] key1         [2];
   logic        mode0        [2];
   logic        mode1        [2];
   logic        grant0       [2];
   logic        grant1       [2];
   logic        rsp_valid0   [2];
   logic        rsp_valid1   [2];
   logic [63:0] rsp_data     [2];
   logic        rsp_err      [2];
   logic        rsp_ack0     [2];
   logic        rsp_ack1     [2];
   logic [63:0] core_message [2];
   logic [63:0] core_key     [2];
   logic        core_mode    [2];
   logic        core_enable  [2];
   logic        core_done    [2];
   logic [63:0] core_result  [2];
   logic        core_ack     [2];
   logic        core_abort   [2];
   logic        busy         [2];

   int   checks;
   int   errors;
   logic model_last [2];  // 1 = channel 1 was served last

   des_core_scheduler #(.TIMEOUT_CYCLES(TO_A), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst[0]), .req0(req0[0]), .req1(req1[0]),
      .msg0(msg0[0]), .msg1(msg1[0]), .key0(key0[0]), .key1(key1[0]),
      .mode0(mode0[0]), .mode1(mode1[0]), .grant0(grant0[0]), .grant1(grant1[0]),
      .rsp_valid0(rsp_valid0[0]), .rsp_valid1(rsp_valid1[0]), .rsp_data(rsp_data[0]),
      .rsp_err(rsp_err[0]), .rsp_ack0(rsp_ack0[0]), .rsp_ack1(rsp_ack1[0]),
      .core_message(core_message[0]), .core_key(core_key[0]), .core_mode(core_mode[0]),
      .core_enable(core_enable[0]), .core_done(core_done[0]),
      .core_result(core_result[0]), .core_ack(core_ack[0]), .core_abort(core_abort[0]),
      .busy(busy[0])
   );

   des_core_scheduler #(.TIMEOUT_CYCLES(TO_B), .CNT_W(16)) dut_b (
      .clk(clk), .reset(rst[1]), .req0(req0[1]), .req1(req1[1]),
      .msg0(msg0[1]), .msg1(msg1[1]), .key0(key0[1]), .key1(key1[1]),
      .mode0(mode0[1]), .mode1(mode1[1]), .grant0(grant0[1]), .grant1(grant1[1]),
      .rsp_valid0(rsp_valid0[1]), .rsp_valid1(rsp_valid1[1]), .rsp_data(rsp_data[1]),
      .rsp_err(rsp_err[1]), .rsp_ack0(rsp_ack0[1]), .rsp_ack1(rsp_ack1[1]),
      .core_message(core_message[1]), .core_key(core_key[1]), .core_mode(core_mode[1]),
      .core_enable(core_enable[1]), .core_done(core_done[1]),
      .core_result(core_result[1]), .core_ack(core_ack[1]), .core_abort(core_abort[1]),
      .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Lone request wins; on a tie the channel not served last wins.
   function automatic int exp_ch(input logic r0, input logic r1, input logic last);
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      return last ? 0 : 1;
   endfunction

   task automatic zero_check(input int d, input string tag);
      chk({tag, "_ctrl"}, 64'({grant1[d], grant0[d], rsp_valid1[d], rsp_valid0[d], rsp_err[d],
                               core_mode[d], core_enable[d], core_ack[d], core_abort[d],
                               busy[d]}), 64'(0));
      chk({tag, "_rsp_data"}, rsp_data[d], 64'(0));
      chk({tag, "_core_message"}, core_message[d], 64'(0));
      chk({tag, "_core_key"}, core_key[d], 64'(0));
   endtask

   task automatic set_req(input int d, input int ch, input logic v, input bit fresh);
      if (ch == 0) begin
         req0[d] = v;
         if (fresh) begin
            msg0[d]  = {$urandom, $urandom};
            key0[d]  = {$urandom, $urandom};
            mode0[d] = 1'($urandom_range(0, 1));
         end
      end else begin
         req1[d] = v;
         if (fresh) begin
            msg1[d]  = {$urandom, $urandom};
            key1[d]  = {$urandom, $urandom};
            mode1[d] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // One complete job, starting at a falling edge with the DUT idle and requests set.
   task automatic job(input int d, input int lat, input int ack_delay, input bit timeout,
                      input bit stray, input bit restart, input logic [63:0] res,
                      output int got);
      int          ch;
      int          n;
      int          k;
      logic [63:0] emsg;
      logic [63:0] ekey;
      logic [63:0] eres;
      logic        emode;
      logic [1:0]  evalid;
      ch     = exp_ch(req0[d], req1[d], model_last[d]);
      emsg   = (ch == 1) ? msg1[d] : msg0[d];
      ekey   = (ch == 1) ? key1[d] : key0[d];
      emode  = (ch == 1) ? mode1[d] : mode0[d];
      evalid = (ch == 1) ? 2'b10 : 2'b01;
      eres   = timeout ? 64'(0) : res;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(grant0[d] || grant1[d]) && n < 8);
      got = grant1[d] ? 1 : 0;
      chk("grant_delay", 64'(n), 64'(1));
      chk("grant_onehot", 64'({grant1[d], grant0[d]}), 64'(evalid));
      chk("core_message", core_message[d], emsg);
      chk("core_key", core_key[d], ekey);
      chk("mode_enable_busy", 64'({core_mode[d], core_enable[d], busy[d]}),
          64'({emode, 1'b1, 1'b1}));
      set_req(d, ch, restart, restart);

      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) chk("grant_pulse", 64'({grant1[d], grant0[d]}), 64'(0));
         if (core_ack[d] || core_abort[d]) break;
         if (!timeout && k == lat) begin
            core_done[d]   = 1'b1;
            core_result[d] = res;
         end
      end
      core_done[d] = 1'b0;
      chk("resp_cycle", 64'(k), timeout ? 64'((d == 0) ? TO_A : TO_B) : 64'(lat + 1));
      chk("rsp_valid", 64'({rsp_valid1[d], rsp_valid0[d]}), 64'(evalid));
      chk("rsp_data", rsp_data[d], eres);
      chk("err_ack_abort_en", 64'({rsp_err[d], core_ack[d], core_abort[d], core_enable[d]}),
          timeout ? 64'(4'b1010) : 64'(4'b0100));

      for (int i = 0; i < ack_delay; i++) begin
         if (stray) begin
            if (ch == 1) rsp_ack0[d] = (i % 2 == 0);
            else         rsp_ack1[d] = (i % 2 == 0);
         end
         @(negedge clk);
         chk("hold_valid", 64'({rsp_valid1[d], rsp_valid0[d]}), 64'(evalid));
         chk("hold_data", rsp_data[d], eres);
         chk("hold_misc", 64'({rsp_err[d], grant1[d], grant0[d], core_ack[d], core_abort[d]}),
             64'({timeout, 4'b0000}));
         chk("hold_message", core_message[d], emsg);
      end
      rsp_ack0[d] = 1'b0;
      rsp_ack1[d] = 1'b0;

      if (ch == 1) rsp_ack1[d] = 1'b1;
      else         rsp_ack0[d] = 1'b1;
      @(negedge clk);
      rsp_ack0[d] = 1'b0;
      rsp_ack1[d] = 1'b0;
      chk("resp_exit", 64'({rsp_valid1[d], rsp_valid0[d], busy[d], grant1[d], grant0[d],
                            core_ack[d], core_abort[d]}), 64'(0));
      model_last[d] = (ch == 1);
   endtask

   initial begin
      int got;
      checks = 0;
      errors = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; req0[d] = 1'b0; req1[d] = 1'b0;
         msg0[d] = '0; msg1[d] = '0; key0[d] = '0; key1[d] = '0;
         mode0[d] = 1'b0; mode1[d] = 1'b0; rsp_ack0[d] = 1'b0; rsp_ack1[d] = 1'b0;
         core_done[d] = 1'b0; core_result[d] = '0; model_last[d] = 1'b1;
      end
      repeat (2) @(negedge clk);
      zero_check(0, "reset_a");
      zero_check(1, "reset_b");
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      @(negedge clk);

      // Reference vector job with a 20-cycle core.
      msg0[0]  = 64'h0123456789ABCDEF;
      key0[0]  = 64'h133457799BBCDFF1;
      mode0[0] = 1'b0;
      req0[0]  = 1'b1;
      job(0, 20, 2, 1'b0, 1'b0, 1'b0, 64'h85E813540F0AB405, got);
      chk("vector_channel", 64'(got), 64'(0));

      // Minimum latency: done in the first RUN cycle.
      set_req(0, 1, 1'b1, 1'b1);
      job(0, 1, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, got);

      // Back-pressure with a pending req1 and stray rsp_ack1.
      set_req(0, 0, 1'b1, 1'b1);
      set_req(0, 1, 1'b1, 1'b1);
      job(0, 4, 10, 1'b0, 1'b1, 1'b0, {$urandom, $urandom}, got);
      chk("bp_first", 64'(got), 64'(0));
      job(0, 2, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, got);
      chk("bp_second", 64'(got), 64'(1));

      // Reset in RUN, then contention from a fresh round-robin state.
      set_req(0, 0, 1'b1, 1'b1);
      set_req(0, 1, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      chk("pre_reset_enable", 64'(core_enable[0]), 64'(1));
      #2 rst[0] = 1'b0;
      #1 zero_check(0, "async_reset");
      @(negedge clk);
      rst[0] = 1'b1;
      model_last[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         job(0, 2, 0, 1'b0, 1'b0, (i < 3), {$urandom, $urandom}, got);
         chk("rr_order", 64'(got), 64'(i % 2));
      end

      // Randomized traffic with pending requests carried across jobs.
      for (int it = 0; it < 25; it++) begin
         if (!req0[0] && $urandom_range(0, 1) == 1) set_req(0, 0, 1'b1, 1'b1);
         if (!req1[0] && $urandom_range(0, 1) == 1) set_req(0, 1, 1'b1, 1'b1);
         if (!req0[0] && !req1[0]) set_req(0, int'($urandom_range(0, 1)), 1'b1, 1'b1);
         job(0, int'($urandom_range(1, 8)), int'($urandom_range(0, 4)), 1'b0,
             1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom}, got);
      end

      // Short-timeout instance: abort, normal follow-up, done in the last cycle.
      set_req(1, 0, 1'b1, 1'b1);
      job(1, 0, 2, 1'b1, 1'b0, 1'b0, 64'(0), got);
      set_req(1, 1, 1'b1, 1'b1);
      job(1, 3, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, got);
      chk("followup_channel", 64'(got), 64'(1));
      set_req(1, 0, 1'b1, 1'b1);
      job(1, TO_B - 1, 1, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, got);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_core_scheduler.md
DES_CORE_SCHEDULER -- requirements
Module: des_core_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning max cycles to wait for core_done before aborting a job (legal range 1..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the timeout counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0, req1  input  1 each  job request per channel; held high until the matching grant pulse.
REQ-006 msg0, msg1  input  64 each  message block per channel; valid while req high.
REQ-007 key0, key1  input  64 each  DES key per channel; valid while req high.
REQ-008 mode0, mode1  input  1 each  0 = encrypt, 1 = decrypt.
REQ-009 grant0, grant1  output  1 each  one-cycle pulse: the channel's job is accepted and its inputs were latched.
REQ-010 rsp_valid0, rsp_valid1  output  1 each  result available for that channel.
REQ-011 rsp_data  output  64  result block, shared; meaningful only while a rsp_valid is high.
REQ-012 rsp_err  output  1  timeout flag for the current response.
REQ-013 rsp_ack0, rsp_ack1  input  1 each  requester consumes the response.
REQ-014 core_message, core_key  output  64 each  latched job operands driven to the DES core.
REQ-015 core_mode  output  1  latched mode.
REQ-016 core_enable  output  1  starts and holds the core run.
REQ-017 core_done  input  1  core result valid.
REQ-018 core_result  input  64  core output block.
REQ-019 core_ack  output  1  one-cycle pulse acknowledging core_done.
REQ-020 core_abort  output  1  one-cycle pulse forcing the core back to its initial state.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, START, RUN, RESP, with transitions only as listed below.
REQ-023 IDLE: if req0 or req1 is high, the block SHALL select a channel round-robin, latch its msg, key and mode, and go to START; otherwise it stays in IDLE.
REQ-024 Round-robin: with both requests high, the channel not served last SHALL win; after reset ch0 has priority; with a single request, that channel SHALL win regardless of history.
REQ-025 START (1 cycle): the block SHALL pulse the granted channel's grant, assert core_enable, clear the timer, and go to RUN.
REQ-026 RUN: core_enable SHALL stay high and the timer SHALL increment each cycle.
REQ-027 RUN exit on core_done: the block SHALL capture core_result into rsp_data, set rsp_err=0, pulse core_ack in the same cycle it samples core_done, drop core_enable, and go to RESP.
REQ-028 RUN exit on timeout: when the timer reaches TIMEOUT_CYCLES-1 without core_done, the block SHALL pulse core_abort, set rsp_data=0 and rsp_err=1, drop core_enable, and go to RESP.
REQ-029 If core_done arrives in the timeout cycle, core_done SHALL win (rsp_err=0, no core_abort).
REQ-030 RESP: the block SHALL hold the granted channel's rsp_valid, rsp_data and rsp_err stable until that channel's rsp_ack; on that edge it clears rsp_valid, records the served channel for round-robin, and goes to IDLE.
REQ-031 The block SHALL ignore rsp_ack from the non-granted channel, and SHALL ignore rsp_ack outside RESP.
REQ-032 Requests arriving outside IDLE SHALL be held pending and are not lost; a request is consumed only by its grant pulse.
REQ-033 The block SHALL keep core_message, core_key and core_mode stable from START through the RESP exit.
REQ-034 Minimum latency from req high (in IDLE) to rsp_valid SHALL be 3 cycles plus core latency (IDLE, START, RUN with core_done asserted immediately).
REQ-035 The block SHALL hold at most one job in flight; there is no output queue.

Reset
REQ-036 With reset low, the block SHALL asynchronously force state to IDLE, the round-robin pointer to ch0 priority, and every output to 0 (including busy, grants, rsp_valid, rsp_data, rsp_err and all core_* outputs).
REQ-037 A reset asserted mid-job SHALL discard the job without issuing core_ack, core_abort or a response; the requester re-issues it.

Structure
REQ-038 Package des_pkg SHALL hold the FSM state enum, the MODE_ENCRYPT/MODE_DECRYPT constants, and the DES_BLOCK_W=64 and DES_KEY_W=64 localparams.
REQ-039 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0] and last-served; output one-hot select); the FSM and timer stay in the top module.

Verification
REQ-040 Single job: req0 with key 133457799BBCDFF1, msg 0123456789ABCDEF, mode 0; core model returns 85E813540F0AB405 after 20 cycles -> grant0 pulses once, rsp_valid0 with that data and rsp_err=0, core_ack 1 pulse.
REQ-041 Contention: req0 and req1 held high for 4 back-to-back jobs -> grant order ch0, ch1, ch0, ch1, with no channel starved.
REQ-042 Timeout: TIMEOUT_CYCLES=8 and the core never asserts done -> core_abort pulses 8 cycles after START, rsp_data=0 and rsp_err=1; a follow-up job then completes normally.
REQ-043 Done-at-timeout: core_done asserted exactly in cycle TIMEOUT_CYCLES-1 -> rsp_err=0, no core_abort.
REQ-044 Back-pressure: rsp_ack0 withheld for 10 cycles while req1 is high -> rsp_data stays stable, no grant1 until 1 cycle after rsp_ack0, rsp_ack1 during this window ignored.
REQ-045 Reset mid-RUN: reset driven low while in RUN -> all outputs 0 immediately (asynchronous); after release, simultaneous req0/req1 grants ch0 first.
